// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 frame buffer blocks.
package hub75_pkg;

  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} swap_state_t;

  localparam int BPP_DEF = 8;
  typedef logic [3*BPP_DEF-1:0] pixel_t;

  function automatic int frame_size(input int h, input int v);
    return h * v;
  endfunction

  function automatic int addr_width(input int h, input int v);
    return $clog2(h * v);
  endfunction

endpackage

// File: rtl/hub75_framebuf_swap_ctrl.sv
// Ping-pong frame buffer controller: host writes the back bank, display reads
// the front bank, swaps are deferred to frame end and may clear the new back bank.
module hub75_framebuf_swap_ctrl
  import hub75_pkg::*;
#(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  localparam int frame_size_p    = frame_size(hpixel_p, vpixel_p),
  localparam int addr_width_p    = addr_width(hpixel_p, vpixel_p),
  localparam int rd_addr_width_p = $clog2(frame_size_p / segments_p)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [addr_width_p-1:0]             i_wr_addr,
  input  logic [3*bpp_p-1:0]                  i_wr_data,
  input  logic                                i_wr_en,
  output logic                                o_wr_ready,
  input  logic                                i_swap_req,
  input  logic                                i_clear_on_swap,
  output logic                                o_swap_pending,
  output logic                                o_swap_done,
  output logic                                o_swap_drop,
  input  logic                                i_frame_end,
  input  logic [rd_addr_width_p-1:0]          i_rd_addr,
  output logic [segments_p*3*bpp_p-1:0]       o_rd_data,
  output logic                                o_front_sel,
  output logic [1:0]                          o_bank_wr_en,
  output logic [addr_width_p-1:0]             o_bank_wr_addr,
  output logic [3*bpp_p-1:0]                  o_bank_wr_data,
  output logic [rd_addr_width_p-1:0]          o_bank_rd_addr,
  input  logic [2*segments_p*3*bpp_p-1:0]     i_bank_rd_data
);

  localparam int PixW = 3 * bpp_p;
  localparam int RdW  = segments_p * PixW;
  localparam logic [addr_width_p:0] LastCnt = (addr_width_p+1)'(frame_size_p - 1);

  swap_state_t               state_q;
  logic                      front_q, clear_q, rd_sel_q;
  logic                      wr_ready_q, pending_q, done_q, drop_q, clr_fin_q;
  logic [addr_width_p:0]     cnt_q;
  logic [1:0]                wr_en_q;
  logic [addr_width_p-1:0]   wr_addr_q;
  logic [PixW-1:0]           wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      clear_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_ready_q <= 1'b1;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      clr_fin_q  <= 1'b0;
      cnt_q      <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q   <= '0;
      drop_q    <= 1'b0;
      clr_fin_q <= 1'b0;
      done_q    <= clr_fin_q;
      rd_sel_q  <= front_q;
      // Back bank is judged by the pre-edge front, so a write in the toggle
      // cycle lands in the bank that is becoming front.
      if (i_wr_en && wr_ready_q) begin
        wr_en_q   <= front_q ? 2'b01 : 2'b10;
        wr_addr_q <= i_wr_addr;
        wr_data_q <= i_wr_data;
      end
      unique case (state_q)
        IDLE: begin
          wr_ready_q <= 1'b1;
          if (i_swap_req) begin
            state_q   <= PENDING;
            pending_q <= 1'b1;
            clear_q   <= i_clear_on_swap;
          end
        end
        PENDING: begin
          drop_q <= i_swap_req;
          if (i_frame_end) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
            if (clear_q) begin
              state_q    <= CLEAR;
              cnt_q      <= '0;
              wr_ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // Ready stays low through the cycle showing the final clear write.
          drop_q    <= i_swap_req;
          wr_en_q   <= front_q ? 2'b01 : 2'b10;
          wr_addr_q <= cnt_q[addr_width_p-1:0];
          wr_data_q <= '0;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q   <= IDLE;
            clr_fin_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wr_ready     = wr_ready_q;
  assign o_swap_pending = pending_q;
  assign o_swap_done    = done_q;
  assign o_swap_drop    = drop_q;
  assign o_front_sel    = front_q;
  assign o_bank_wr_en   = wr_en_q;
  assign o_bank_wr_addr = wr_addr_q;
  assign o_bank_wr_data = wr_data_q;
  assign o_bank_rd_addr = i_rd_addr;
  assign o_rd_data      = rd_sel_q ? i_bank_rd_data[2*RdW-1:RdW] : i_bank_rd_data[RdW-1:0];

endmodule
